// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master sequencer driving an external shift register (load/shift) plus sclk/cs_n, capturing miso MSB first.
module spi_master_ctrl #(
  parameter int Register_Width = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [Register_Width-1:0] tx_data,
  input  logic                      miso,
  output logic [Register_Width-1:0] Data,
  output logic                      Load_Enable,
  output logic                      shift_right,
  output logic                      sclk,
  output logic                      cs_n,
  output logic                      busy,
  output logic                      done,
  output logic [Register_Width-1:0] rx_data
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(Register_Width + 1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, LOW = 3'd2, HIGH = 3'd3, TAIL = 3'd4;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(Register_Width - 1);
  logic [2:0] state;
  logic [DW-1:0] div;
  logic [BW-1:0] bit_cnt;
  logic [Register_Width-1:0] rx_sh;
  logic div_end;
  assign div_end = div == DIV_LAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      Data <= '0;
      Load_Enable <= 1'b0;
      shift_right <= 1'b0;
      sclk <= 1'b0;
      cs_n <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      Load_Enable <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          Data <= tx_data;
          cs_n <= 1'b0;
          busy <= 1'b1;
          Load_Enable <= 1'b1;
        end
        LOAD: begin
          state <= LOW;
          shift_right <= 1'b1;
          div <= '0;
          bit_cnt <= '0;
        end
        LOW: if (div_end) begin
          state <= HIGH;
          div <= '0;
          sclk <= 1'b1;
          rx_sh <= {rx_sh[Register_Width-2:0], miso};
        end else div <= div + 1'b1;
        HIGH: if (div_end) begin
          div <= '0;
          sclk <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
          state <= (bit_cnt == BIT_LAST) ? TAIL : LOW;
          shift_right <= bit_cnt != BIT_LAST;
        end else div <= div + 1'b1;
        TAIL: if (div_end) begin
          state <= IDLE;
          div <= '0;
          cs_n <= 1'b1;
          busy <= 1'b0;
          done <= 1'b1;
          rx_data <= rx_sh;
        end else div <= div + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed checks of spi_master_ctrl at 8/2 and the CLK_DIV=1 corner.
module tb_spi_master_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0, ld = 1'b0;
  logic [7:0] tx = '0, tx1 = '0;
  logic [15:0] slv_word = '0, slv = '0;
  logic [7:0] data, rx, data1, rx1;
  logic le, sr, sclk, cs_n, busy, done, le1, sr1, sclk1, cs_n1, busy1, done1;
  int errs = 0, checks = 0;
  int m_rises, m_highs, m_loads, m_dones, m_done_at, m_rise_at, m_data_bad, m_rx_bad, m_both;
  always #5 clk = ~clk;
  // slave shifts out MSB first, advancing on each sclk fall
  always @(negedge sclk or posedge ld) slv = ld ? slv_word : slv << 1;
  spi_master_ctrl #(.Register_Width(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx), .miso(slv[15]),
    .Data(data), .Load_Enable(le), .shift_right(sr), .sclk(sclk),
    .cs_n(cs_n), .busy(busy), .done(done), .rx_data(rx));
  spi_master_ctrl #(.Register_Width(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .miso(1'b1),
    .Data(data1), .Load_Enable(le1), .shift_right(sr1), .sclk(sclk1),
    .cs_n(cs_n1), .busy(busy1), .done(done1), .rx_data(rx1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] d, input logic [15:0] s);
    @(negedge clk);
    slv_word = s;
    ld = 1'b1;
    tx = d;
    start = 1'b1;
    #1 ld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("load_pulse", le, 1'b1);
    chk("load_csn_low", cs_n, 1'b0);
    start = 1'b0;
  endtask
  task automatic mon(input int n, input logic [7:0] exp_d, input bit inj);
    logic [7:0] rx_prev;
    logic prev_s;
    rx_prev = rx;
    prev_s = sclk;
    {m_rises, m_highs, m_loads, m_dones, m_data_bad, m_rx_bad, m_both} = '0;
    m_done_at = -1;
    m_rise_at = -1;
    for (int c = 1; c <= n; c++) begin
      if (inj && c == 10) begin start = 1'b1; tx = 8'hFF; end
      if (inj && c == 12) start = 1'b0;
      @(negedge clk);
      if (sclk && !prev_s) begin m_rises++; if (m_rise_at < 0) m_rise_at = c; end
      if (sclk) m_highs++;
      if (le) m_loads++;
      if (le && done) m_both++;
      if (done) begin m_dones++; if (m_done_at < 0) m_done_at = c; rx_prev = rx; end
      if (rx !== rx_prev) m_rx_bad++;
      if (data !== exp_d) m_data_bad++;
      prev_s = sclk;
    end
  endtask
  initial begin
    int d1, d2, csn_hi, loads, rises, toggles, ok;
    logic p;
    #2 rst = 1'b0;
    #1;
    chk("rst_csn", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_le", le, 1'b0);
    chk("rst_sr", sr, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_rx", rx, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // basic transfer
    go(8'hA5, 16'h3C00);
    chk("basic_busy", busy, 1'b1);
    mon(45, 8'hA5, 1'b0);
    chk("basic_rises", m_rises, 8);
    chk("basic_highs", m_highs, 16);
    chk("basic_first_rise", m_rise_at, 3);
    chk("basic_done_at", m_done_at, 35);
    chk("basic_dones", m_dones, 1);
    chk("basic_extra_load", m_loads, 0);
    chk("basic_data", m_data_bad, 0);
    chk("basic_rx_stable", m_rx_bad, 0);
    chk("basic_rx", rx, 8'h3C);
    chk("basic_sr_idle", sr, 1'b0);
    chk("basic_csn_idle", cs_n, 1'b1);
    // start while busy is ignored
    go(8'hA5, 16'h9600);
    mon(45, 8'hA5, 1'b1);
    chk("ign_rises", m_rises, 8);
    chk("ign_done_at", m_done_at, 35);
    chk("ign_dones", m_dones, 1);
    chk("ign_loads", m_loads, 0);
    chk("ign_data", m_data_bad, 0);
    chk("ign_rx", rx, 8'h96);
    // back-to-back with start held
    @(negedge clk);
    slv_word = 16'h5AC3;
    ld = 1'b1;
    tx = 8'h12;
    start = 1'b1;
    #1 ld = 1'b0;
    @(posedge clk);
    {d1, d2, csn_hi, loads} = '0;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (c == 5) tx = 8'h34;
      if (c == 71) start = 1'b0;
      if (done) begin if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c; end
      if (c >= 1 && c < 71 && cs_n) csn_hi++;
      if (le) loads++;
      if (le && done) loads += 100;
      if (c == 20) chk("b2b_data1", data, 8'h12);
      if (c == 35) chk("b2b_rx1", rx, 8'h5A);
      if (c == 36) chk("b2b_load2_csn", {le, cs_n}, 2'b10);
      if (c == 50) chk("b2b_data2", data, 8'h34);
    end
    chk("b2b_done1", d1, 35);
    chk("b2b_done2", d2, 71);
    chk("b2b_csn_gap", csn_hi, 1);
    chk("b2b_loads", loads, 2);
    chk("b2b_rx2", rx, 8'hC3);
    // reset mid-transfer after the 3rd sclk rise
    go(8'h77, 16'hFF00);
    p = sclk;
    rises = 0;
    ok = 0;
    for (int c = 1; c <= 40 && !ok; c++) begin
      @(negedge clk);
      if (sclk && !p) rises++;
      p = sclk;
      if (rises == 3) ok = 1;
    end
    chk("mid_reach_3rd_rise", ok, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_csn", cs_n, 1'b1);
    chk("mid_sclk", sclk, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_rx", rx, 8'h00);
    chk("mid_data", data, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon(40, 8'h00, 1'b0);
    chk("mid_no_done", m_dones, 0);
    chk("mid_no_sclk", m_rises, 0);
    go(8'h55, 16'hE100);
    mon(40, 8'h55, 1'b0);
    chk("fresh_done_at", m_done_at, 35);
    chk("fresh_rises", m_rises, 8);
    chk("fresh_rx", rx, 8'hE1);
    chk("fresh_data", m_data_bad, 0);
    // CLK_DIV=1 corner
    @(negedge clk);
    tx1 = 8'h81;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("div1_load", {le1, cs_n1}, 2'b10);
    start1 = 1'b0;
    {rises, toggles, d1} = '0;
    p = sclk1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (sclk1 && !p) rises++;
      if (sclk1 != p) toggles++;
      if (done1 && d1 == 0) d1 = c;
      p = sclk1;
    end
    chk("div1_rises", rises, 8);
    chk("div1_toggles", toggles, 16);
    chk("div1_done_at", d1, 18);
    chk("div1_rx", rx1, 8'hFF);
    chk("div1_data", data1, 8'h81);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
